// File: rtl/pulse_code_rx_if.sv
// Line and output-slot signals of the pulse-code receiver.
// The master side drives the raw line and ready_in; the slave side is the receiver itself.
interface pulse_code_rx_if #(
    parameter int WIDTH = 8
);
    logic             signal_in;
    logic             ready_in;
    logic [WIDTH-1:0] code_out;
    logic             valid_out;
    logic             repeat_out;
    logic             overrun_out;
    logic [2:0]       error_out;
    logic [3:0]       state_out;

    modport master (
        output signal_in, ready_in,
        input  code_out, valid_out, repeat_out, overrun_out, error_out, state_out
    );

    modport slave (
        input  signal_in, ready_in,
        output code_out, valid_out, repeat_out, overrun_out, error_out, state_out
    );
endinterface

// File: rtl/pulse_code_rx.sv
// Pulse-width frame receiver: sync + filter front end, run-length FSM, parity, repeat and timeout detection.
// Line-to-filter latency 2+FILTER_LEN cycles; a full output slot drops new frames (overrun) rather than stalling.
module pulse_code_rx #(
    parameter int SBD        = 800,
    parameter int SSD        = 800,
    parameter int RSD        = 400,
    parameter int BBD        = 400,
    parameter int BSD0       = 200,
    parameter int BSD1       = 400,
    parameter int MARGIN     = 100,
    parameter int WIDTH      = 8,
    parameter int PARITY_EN  = 1,
    parameter int FILTER_LEN = 4,
    parameter int CNT_W      = 16
) (
    input  logic           clk_in,
    input  logic           rst_in,
    pulse_code_rx_if.slave bus
);
    localparam int NB        = WIDTH + PARITY_EN;
    localparam int BC_W      = $clog2(NB + 1);
    localparam int FC_W      = $clog2(FILTER_LEN + 1);
    localparam int TO_SYNC_L = ((SSD > RSD) ? SSD : RSD) + MARGIN;
    localparam int TO_BIT_L  = ((BSD1 > BSD0) ? BSD1 : BSD0) + MARGIN;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SYNC_H = 4'd1,
        ST_SYNC_L = 4'd2,
        ST_BIT_H  = 4'd3,
        ST_BIT_L  = 4'd4,
        ST_DONE   = 4'd5
    } state_t;

    function automatic logic in_win(input int d, input int c);
        return (d >= c - MARGIN) && (d <= c + MARGIN);
    endfunction

    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             filt_q, filt_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [NB-1:0]    sr_q, sr_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic             have_code_q, have_code_d;
    logic             repeat_q, repeat_d;
    logic             overrun_q, overrun_d;
    logic [2:0]       err_q, err_d;

    logic flip, rise, fall, bit_val, parity_bad;
    int   dur;

    // Front end: two-flop synchroniser, then a run-length glitch filter.
    always_comb begin
        sync1_d = bus.signal_in;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        fcnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == FC_W'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // cnt_q equals the number of cycles the current filtered level has lasted,
    // so on the cycle a flip is decided it is exactly the duration of the ending level.
    always_comb begin
        flip  = (filt_d != filt_q);
        rise  = flip & ~filt_q;
        fall  = flip & filt_q;
        dur   = int'(cnt_q);
        cnt_d = flip ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        code_d      = code_q;
        valid_d     = valid_q;
        have_code_d = have_code_q;
        repeat_d    = 1'b0;
        overrun_d   = 1'b0;
        err_d       = err_q;
        bit_val     = 1'b0;
        parity_bad  = (PARITY_EN != 0) && (^sr_q);

        if (valid_q && bus.ready_in) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d   = ST_SYNC_H;
                    err_d     = 3'd0;
                    bit_cnt_d = '0;
                    sr_d      = '0;
                end
            end
            // High levels always end in a fall that gets classified, so only
            // silences (where an idle low line could stall the FSM) time out.
            ST_SYNC_H: begin
                if (fall) begin
                    if (in_win(dur, SBD)) begin
                        state_d = ST_SYNC_L;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 3'd1;
                    end
                end
            end
            ST_SYNC_L: begin
                if (rise) begin
                    if (in_win(dur, SSD)) begin
                        state_d = ST_BIT_H;
                    end else if (in_win(dur, RSD)) begin
                        state_d  = ST_IDLE;
                        repeat_d = have_code_q;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 3'd1;
                    end
                end else if (dur > TO_SYNC_L) begin
                    state_d = ST_IDLE;
                    err_d   = 3'd5;
                end
            end
            ST_BIT_H: begin
                if (fall) begin
                    if (in_win(dur, BBD)) begin
                        state_d = ST_BIT_L;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 3'd2;
                    end
                end
            end
            ST_BIT_L: begin
                if (rise) begin
                    if (in_win(dur, BSD0) || in_win(dur, BSD1)) begin
                        bit_val   = !in_win(dur, BSD0);
                        sr_d      = (sr_q << 1) | NB'(bit_val);
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        state_d   = (bit_cnt_q == BC_W'(NB - 1)) ? ST_DONE : ST_BIT_H;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 3'd3;
                    end
                end else if (dur > TO_BIT_L) begin
                    state_d = ST_IDLE;
                    err_d   = 3'd5;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (parity_bad) begin
                    err_d = 3'd4;
                end else if (!valid_q || bus.ready_in) begin
                    code_d      = sr_q[NB-1 -: WIDTH];
                    valid_d     = 1'b1;
                    have_code_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                    err_d     = 3'd6;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_q      <= 1'b0;
            fcnt_q      <= '0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            code_q      <= '0;
            valid_q     <= 1'b0;
            have_code_q <= 1'b0;
            repeat_q    <= 1'b0;
            overrun_q   <= 1'b0;
            err_q       <= 3'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            have_code_q <= have_code_d;
            repeat_q    <= repeat_d;
            overrun_q   <= overrun_d;
            err_q       <= err_d;
        end
    end

    assign bus.code_out    = code_q;
    assign bus.valid_out   = valid_q;
    assign bus.repeat_out  = repeat_q;
    assign bus.overrun_out = overrun_q;
    assign bus.error_out   = err_q;
    assign bus.state_out   = state_q;

endmodule
